// File: rtl/wb_defs.sv
// wb_defs: shared FSM state encoding and default bus widths for the Wishbone interconnect
package wb_defs;
  localparam int WB_DW = 32;
  localparam int WB_AW = 32;
  localparam int WB_SW = 4;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWNED = 2'd1,
    ERR   = 2'd2
  } wb_state_e;
endpackage

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: round-robin pick of the first requester at or after i_ptr
// Ports: i_req request vector, i_ptr scan start index, o_grant one-hot winner (all zero when idle).
module wb_rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant
);
  logic [2*N-1:0] w_rot;
  logic [2*N-1:0] w_back;
  logic [N-1:0]   w_low;
  // rotate so i_ptr sits at bit 0, isolate the lowest set bit, rotate back
  assign w_rot   = {i_req, i_req} >> i_ptr;
  assign w_low   = w_rot[N-1:0] & -w_rot[N-1:0];
  assign w_back  = {w_low, w_low} << i_ptr;
  assign o_grant = w_back[2*N-1:N];
endmodule

// File: rtl/wb_interconnect.sv
// wb_interconnect: shared-bus Wishbone interconnect with round-robin arbitration and address decode
// Ports: clk_i/rst_i; m_* flattened master requests with per-master ack/err and shared read data;
// s_* broadcast request, per-slave stb/cyc, flattened slave responses; grant_o one-hot bus owner.
// Define WB_INTERCONNECT_TIMEOUT_EN to add a slave response timeout that terminates with err.
module wb_interconnect
  import wb_defs::*;
#(
  parameter int WB_DATA_WIDTH  = WB_DW,
  parameter int WB_ADDR_WIDTH  = WB_AW,
  parameter int WB_SEL_WIDTH   = WB_SW,
  parameter int NUM_MASTERS    = 2,
  parameter int NUM_SLAVES     = 3,
  parameter logic [NUM_SLAVES*WB_ADDR_WIDTH-1:0] SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES*WB_ADDR_WIDTH-1:0] SLAVE_MASK = '0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NUM_MASTERS*WB_ADDR_WIDTH-1:0]  m_addr_i,
  input  logic [NUM_MASTERS*WB_DATA_WIDTH-1:0]  m_data_i,
  input  logic [NUM_MASTERS*WB_SEL_WIDTH-1:0]   m_sel_i,
  input  logic [NUM_MASTERS-1:0]                m_we_i,
  input  logic [NUM_MASTERS-1:0]                m_stb_i,
  input  logic [NUM_MASTERS-1:0]                m_cyc_i,
  output logic [NUM_MASTERS-1:0]                m_ack_o,
  output logic [NUM_MASTERS-1:0]                m_err_o,
  output logic [WB_DATA_WIDTH-1:0]              m_data_o,
  output logic [WB_ADDR_WIDTH-1:0]              s_addr_o,
  output logic [WB_DATA_WIDTH-1:0]              s_data_o,
  output logic [WB_SEL_WIDTH-1:0]               s_sel_o,
  output logic                                  s_we_o,
  output logic [NUM_SLAVES-1:0]                 s_stb_o,
  output logic [NUM_SLAVES-1:0]                 s_cyc_o,
  input  logic [NUM_SLAVES-1:0]                 s_ack_i,
  input  logic [NUM_SLAVES*WB_DATA_WIDTH-1:0]   s_data_i,
  output logic [NUM_MASTERS-1:0]                grant_o
);
  localparam int AW = WB_ADDR_WIDTH;
  localparam int DW = WB_DATA_WIDTH;
  localparam int SW = WB_SEL_WIDTH;
  localparam int NM = NUM_MASTERS;
  localparam int NS = NUM_SLAVES;
  localparam int PW = (NM > 1) ? $clog2(NM) : 1;
  wb_state_e     r_state, w_state_nxt;
  logic [NM-1:0] r_grant, w_grant_nxt, w_arb_grant;
  logic [PW-1:0] r_rr_ptr, w_rr_nxt, w_idx;
  logic [NS-1:0] w_match, w_hit, w_sel_ack;
  logic          w_cyc, w_stb, w_owned, w_ack, w_tmo;
  wb_rr_arbiter #(.N(NM), .PW(PW)) u_arb (
    .i_req  (m_cyc_i),
    .i_ptr  (r_rr_ptr),
    .o_grant(w_arb_grant)
  );
  always_comb begin
    s_addr_o = '0;
    s_data_o = '0;
    s_sel_o  = '0;
    s_we_o   = 1'b0;
    w_idx    = '0;
    for (int k = 0; k < NM; k++) begin
      if (r_grant[k]) begin
        s_addr_o = m_addr_i[k*AW +: AW];
        s_data_o = m_data_i[k*DW +: DW];
        s_sel_o  = m_sel_i[k*SW +: SW];
        s_we_o   = m_we_i[k];
        w_idx    = PW'(k);
      end
    end
  end
  for (genvar g = 0; g < NS; g++) begin : g_dec
    assign w_match[g] = (s_addr_o & SLAVE_MASK[g*AW +: AW]) == (SLAVE_BASE[g*AW +: AW] & SLAVE_MASK[g*AW +: AW]);
  end
  // lowest matching index wins on overlapping windows
  assign w_hit     = w_match & -w_match;
  assign w_cyc     = |(m_cyc_i & r_grant);
  assign w_stb     = w_cyc & |(m_stb_i & r_grant);
  assign w_owned   = (r_state == OWNED) & ~rst_i;
  assign s_cyc_o   = {NS{w_owned & w_cyc}} & w_hit;
  assign s_stb_o   = {NS{w_owned & w_stb}} & w_hit;
  // only the strobed slave may terminate, so stray acks never reach a master
  assign w_sel_ack = s_ack_i & s_stb_o;
  assign w_ack     = |w_sel_ack;
  assign m_ack_o   = {NM{w_ack}} & r_grant;
  assign m_err_o   = {NM{(r_state == ERR) & ~rst_i}} & r_grant;
  assign grant_o   = r_grant;
  always_comb begin
    m_data_o = '0;
    for (int k = 0; k < NS; k++) m_data_o = m_data_o | (s_data_i[k*DW +: DW] & {DW{w_sel_ack[k]}});
  end
`ifdef WB_INTERCONNECT_TIMEOUT_EN
  logic [15:0] r_tmo_cnt;
  always_ff @(posedge clk_i)
    r_tmo_cnt <= (rst_i || !(|s_stb_o) || w_ack) ? '0 : r_tmo_cnt + 1'b1;
  // r_tmo_cnt is the strobe cycle number minus one; firing here makes the err
  // cycle itself the TIMEOUT_CYCLES-th strobe cycle
  assign w_tmo = (|s_stb_o) & ~w_ack & (r_tmo_cnt == 16'(TIMEOUT_CYCLES - 2));
`else
  assign w_tmo = 1'b0;
`endif
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_rr_ptr <= w_rr_nxt;
    end
  end
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_rr_nxt    = r_rr_ptr;
    case (r_state)
      IDLE: if (|m_cyc_i) begin
        w_state_nxt = OWNED;
        w_grant_nxt = w_arb_grant;
      end
      OWNED: if (!w_cyc) begin
        w_state_nxt = IDLE;
        w_grant_nxt = '0;
        w_rr_nxt    = (w_idx == PW'(NM - 1)) ? '0 : w_idx + 1'b1;
      end else if ((w_stb && w_hit == '0) || w_tmo) begin
        w_state_nxt = ERR;
      end
      default: w_state_nxt = OWNED;
    endcase
  end
endmodule

// File: tb/tb_wb_interconnect.sv
// tb_wb_interconnect: scoreboard bench for arbitration, decode, error and reset behaviour
module tb_wb_interconnect;
  localparam int AW = 32, DW = 32, SW = 4, NM = 2, NS = 3;
  logic               clk = 1'b0, rst = 1'b1;
  logic [NM*AW-1:0]   m_addr_i = '0;
  logic [NM*DW-1:0]   m_data_i = '0;
  logic [NM*SW-1:0]   m_sel_i = '1;
  logic [NM-1:0]      m_we_i = '0, m_stb_i = '0, m_cyc_i = '0;
  logic [NM-1:0]      m_ack_o, m_err_o, grant_o;
  logic [DW-1:0]      m_data_o, s_data_o;
  logic [AW-1:0]      s_addr_o;
  logic [SW-1:0]      s_sel_o;
  logic               s_we_o;
  logic [NS-1:0]      s_stb_o, s_cyc_o;
  logic [NS-1:0]      s_ack_i = '0;
  logic [NS*DW-1:0]   s_data_i = '0;
  logic [DW-1:0]      sb_q[$];
  int n_chk = 0, n_pass = 0;
  wb_interconnect #(
    .NUM_MASTERS(NM), .NUM_SLAVES(NS),
    .SLAVE_BASE({32'h0000_0000, 32'h0000_1000, 32'h0000_0000}),
    .SLAVE_MASK({32'hFFFF_0000, 32'hFFFF_F000, 32'hFFFF_F000}),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .m_addr_i(m_addr_i), .m_data_i(m_data_i), .m_sel_i(m_sel_i),
    .m_we_i(m_we_i), .m_stb_i(m_stb_i), .m_cyc_i(m_cyc_i),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_data_o(m_data_o),
    .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_ack_i(s_ack_i), .s_data_i(s_data_i),
    .grant_o(grant_o)
  );
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic drive_m(input int m, input logic cyc, input logic stb, input logic [AW-1:0] addr);
    m_cyc_i[m] = cyc;
    m_stb_i[m] = stb;
    m_addr_i[m*AW +: AW] = addr;
  endtask
  task automatic do_read(input int m, input logic [AW-1:0] addr, input int slv, input logic [DW-1:0] data, input string tag);
    for (int i = 0; i < NS; i++) s_data_i[i*DW +: DW] = (i == slv) ? data : ~data;
    sb_q.push_back(data);
    drive_m(m, 1'b1, 1'b1, addr);
    #1;
    check({tag, "_stb"}, s_stb_o, 64'(1) << slv);
    check({tag, "_idle_data"}, m_data_o, 0);
    @(negedge clk);
    s_ack_i = NS'(1) << slv;
    #1;
    check({tag, "_ack"}, m_ack_o, 64'(1) << m);
    if (m_ack_o[m]) check({tag, "_data"}, m_data_o, sb_q.pop_front());
    @(negedge clk);
    s_ack_i = '0;
    drive_m(m, 1'b1, 1'b0, addr);
  endtask
  initial begin
    int first, errs;
    m_cyc_i = 2'b11;
    s_ack_i = '1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_grant", grant_o, 0);
    check("rst_stb", s_stb_o, 0);
    check("rst_cyc", s_cyc_o, 0);
    check("rst_ack", m_ack_o, 0);
    check("rst_err", m_err_o, 0);
    @(negedge clk);
    rst = 1'b0;
    s_ack_i = '0;
    #1;
    check("grant_latency", grant_o, 0);
    @(negedge clk); #1;
    check("grant_m0", grant_o, 2'b01);
    @(negedge clk);
    do_read(0, 32'h0000_1004, 1, 32'hDEAD_BEEF, "rd_s1");
    do_read(0, 32'h0000_0004, 0, 32'h1234_5678, "rd_overlap_s0");
    drive_m(0, 1'b1, 1'b1, 32'h0000_2008);
    s_ack_i = 3'b011;
    s_data_i = '1;
    #1;
    check("stray_stb", s_stb_o, 3'b100);
    check("stray_ack", m_ack_o, 0);
    check("stray_data", m_data_o, 0);
    @(negedge clk);
    s_ack_i = '0;
    drive_m(0, 1'b0, 1'b0, 0);
    #1;
    check("release_stb", s_stb_o, 0);
    @(negedge clk); #1;
    check("release_grant", grant_o, 0);
    m_cyc_i[0] = 1'b1;
    @(negedge clk); #1;
    check("rr_grant_m1", grant_o, 2'b10);
    m_cyc_i[0] = 1'b0;
    @(negedge clk);
    do_read(1, 32'h0000_2008, 2, 32'hCAFE_F00D, "rd_s2");
    drive_m(1, 1'b1, 1'b1, 32'hF000_0000);
    #1;
    check("unmap_stb", s_stb_o, 0);
    check("unmap_err_early", m_err_o, 0);
    @(negedge clk); #1;
    check("unmap_err", m_err_o, 2'b10);
    drive_m(1, 1'b1, 1'b0, 32'hF000_0000);
    @(negedge clk); #1;
    check("unmap_err_once", m_err_o, 0);
    drive_m(1, 1'b0, 1'b0, 0);
    m_cyc_i[0] = 1'b1;
    @(negedge clk); #1;
    check("m1_release", grant_o, 0);
    m_cyc_i[1] = 1'b1;
    @(negedge clk); #1;
    check("rr_grant_m0", grant_o, 2'b01);
    m_cyc_i[1] = 1'b0;
    drive_m(0, 1'b1, 1'b1, 32'h0000_1004);
    #1;
    check("drop_pre_cyc", s_cyc_o, 3'b010);
    @(negedge clk);
    drive_m(0, 1'b0, 1'b0, 32'h0000_1004);
    #1;
    check("drop_stb", s_stb_o, 0);
    s_ack_i = 3'b010;
    #1;
    check("drop_late_ack", m_ack_o, 0);
    @(negedge clk);
    s_ack_i = '0;
    drive_m(0, 1'b1, 1'b0, 32'h0000_1004);
    @(negedge clk); #1;
    check("regrant_m0", grant_o, 2'b01);
    drive_m(0, 1'b1, 1'b1, 32'h0000_1004);
    #1;
    check("rstx_pre_stb", s_stb_o, 3'b010);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    check("rstx_grant", grant_o, 0);
    check("rstx_stb", s_stb_o, 0);
    s_ack_i = 3'b010;
    #1;
    check("rstx_ack", m_ack_o, 0);
    check("rstx_err", m_err_o, 0);
    @(negedge clk);
    rst = 1'b0;
    s_ack_i = '0;
    drive_m(0, 1'b1, 1'b0, 32'h0000_1004);
    @(negedge clk); #1;
    check("post_rst_grant", grant_o, 2'b01);
    drive_m(0, 1'b1, 1'b1, 32'h0000_1004);
`ifdef WB_INTERCONNECT_TIMEOUT_EN
    first = 0;
    for (int i = 1; i <= 40 && first == 0; i++) begin
      if (i > 1) @(negedge clk);
      #1;
      if (m_err_o[0]) first = i;
    end
    check("tmo_cycle", first, 16);
    check("tmo_stb_low", s_stb_o, 0);
    @(negedge clk); #1;
    check("tmo_err_once", m_err_o, 0);
`else
    errs = 0;
    repeat (1000) begin
      @(negedge clk); #1;
      if (m_err_o != 0) errs++;
    end
    check("no_tmo_err", errs, 0);
    check("stall_stb", s_stb_o, 3'b010);
`endif
    drive_m(0, 1'b0, 1'b0, 0);
    @(negedge clk); #1;
    check("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
